// File: rtl/mem_arb_defs.sv
// mem_arb_defs: shared state encodings and requester indices for the memory port arbiter
package mem_arb_defs;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;
    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick; on contention the requester not granted last time wins
module rr_pick2
    import mem_arb_defs::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       valid,
    output logic       winner
);
    always_comb begin
        valid  = |req;
        winner = &req ? ~last_gnt : (req[1] ? REQ_MEM : REQ_IF);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access,
// one registered transaction at a time, with per-transaction timeout.
module mem_port_arbiter
    import mem_arb_defs::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              sel_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              last_gnt_q, last_gnt_d;
    logic              pick_valid, pick_winner;
    logic [1:0]        done_d;
    logic              err_d, sel_d, req_d, we_d;
    logic [DATA_W-1:0] rdata_d, wdata_d;
    logic [ADDR_W-1:0] addr_d;

    rr_pick2 u_pick (
        .req      (req_i),
        .last_gnt (last_gnt_q),
        .valid    (pick_valid),
        .winner   (pick_winner)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        last_gnt_d = last_gnt_q;
        done_d     = 2'b00;
        err_d      = 1'b0;
        rdata_d    = '0;
        req_d      = 1'b0;
        sel_d      = sel_o;
        we_d       = mem_we_o;
        addr_d     = mem_addr_o;
        wdata_d    = mem_wdata_o;
        case (state_q)
            IDLE: if (pick_valid) begin
                state_d = ISSUE;
                req_d   = 1'b1;
                sel_d   = pick_winner;
                we_d    = pick_winner ? we_i[1] : we_i[0];
                addr_d  = pick_winner ? addr1_i : addr0_i;
                wdata_d = pick_winner ? wdata1_i : wdata0_i;
                timer_d = '0;
            end
            ISSUE: begin
                timer_d = (timer_q == TMAX) ? TMAX : timer_q + 1'b1;
                // an ack arriving on the last allowed cycle still counts as success
                if (mem_ack_i || timer_q == TMAX) begin
                    state_d = RESP;
                    done_d  = sel_o ? 2'b10 : 2'b01;
                    err_d   = ~mem_ack_i;
                    rdata_d = (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;
                end else begin
                    req_d = 1'b1;
                end
            end
            RESP: begin
                last_gnt_d = sel_o;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            last_gnt_q  <= 1'b1;
            done_o      <= 2'b00;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            sel_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            last_gnt_q  <= last_gnt_d;
            done_o      <= done_d;
            err_o       <= err_d;
            rdata_o     <= rdata_d;
            sel_o       <= sel_d;
            mem_req_o   <= req_d;
            mem_we_o    <= we_d;
            mem_addr_o  <= addr_d;
            mem_wdata_o <= wdata_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench with a transaction-level round-robin model
module tb_mem_port_arbiter;
    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_i, we_i;
    logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
    logic [1:0]  done_o;
    logic        err_o, sel_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .sel_o(sel_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        w;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        int          d;
        logic [31:0] rd;
    } resp_t;

    typedef struct {
        logic [1:0]  add;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          d;
        logic [31:0] rd;
        logic        drop;
    } step_t;

    exp_t  eq[$];
    resp_t rq[$];
    int    tests = 0;
    int    fails = 0;
    bit    mon_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // memory responder: acks d cycles after the first mem_req_o cycle
    initial begin
        resp_t cur;
        bit    rprev;
        int    cnt;
        cur = '{100, 32'h0};
        rprev = 0;
        cnt = 0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (mem_req_o) begin
                if (!rprev) begin
                    if (rq.size() != 0) cur = rq.pop_front();
                    cnt = 0;
                end else cnt++;
                mem_ack_i = (cnt == cur.d);
                mem_rdata_i = mem_ack_i ? cur.rd : $urandom;
            end else mem_ack_i = 1'b0;
            rprev = mem_req_o;
        end
    end

    // monitor: checks bus at issue and response at every done_o pulse
    initial begin
        bit   mprev, after;
        int   cyc;
        exp_t e;
        mprev = 0;
        after = 0;
        cyc = 0;
        forever begin
            @(negedge clk_i);
            if (mon_en) begin
                if (mem_req_o && !mprev) begin
                    cyc = 1;
                    if (eq.size() == 0) chk("issue_without_expect", 1, 0);
                    else begin
                        e = eq[0];
                        chk("issue_sel", sel_o, e.w);
                        chk("issue_we", mem_we_o, e.we);
                        chk("issue_addr", mem_addr_o, e.addr);
                        chk("issue_wdata", mem_wdata_o, e.wdata);
                    end
                end else if (mem_req_o) cyc++;
                if (done_o != 2'b00) begin
                    if (eq.size() == 0) chk("unexpected_done", done_o, 0);
                    else begin
                        e = eq.pop_front();
                        chk("done_onehot", done_o, e.w ? 2'b10 : 2'b01);
                        chk("done_err", err_o, e.err);
                        chk("done_rdata", rdata_o, e.rdata);
                        chk("req_cycles", cyc, e.cyc);
                        chk("req_low_in_resp", mem_req_o, 0);
                    end
                    after = 1;
                end else if (after) begin
                    chk("post_done_clear", {err_o, rdata_o}, 0);
                    after = 0;
                end
            end
            mprev = mem_req_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step_t      steps[9];
        step_t      s;
        logic [1:0] p;
        logic       lg, w, got;
        logic       cw[2];
        logic [31:0] ca[2], cd[2];
        int         n;
        steps[0] = '{2'b11, 1'b0, 32'h40, 32'h0, 2, 32'hDEADBEEF, 1'b0};
        steps[1] = '{2'b01, 1'b0, 32'h44, 32'h0, 1, 32'h11112222, 1'b0};
        steps[2] = '{2'b10, 1'b0, 32'h48, 32'h0, 0, 32'h33334444, 1'b0};
        steps[3] = '{2'b01, 1'b0, 32'h4C, 32'h0, 3, 32'h55556666, 1'b0};
        steps[4] = '{2'b10, 1'b1, 32'h80, 32'h12345678, 4, 32'h77778888, 1'b0};
        steps[5] = '{2'b00, 1'b0, 32'h0, 32'h0, 3, 32'hAAAABBBB, 1'b0};
        steps[6] = '{2'b01, 1'b0, 32'hC0, 32'h0, 30, 32'h99990000, 1'b0};
        steps[7] = '{2'b01, 1'b0, 32'hC4, 32'h0, 15, 32'hCAFEF00D, 1'b0};
        steps[8] = '{2'b10, 1'b0, 32'hC8, 32'h0, 6, 32'h0BADF00D, 1'b1};
        cw[0] = 0; cw[1] = 0; ca[0] = 0; ca[1] = 0; cd[0] = 0; cd[1] = 0;
        rst_i = 1'b1;
        req_i = 2'b00; we_i = 2'b00;
        addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
        repeat (2) @(negedge clk_i);
        chk("reset_outputs", {done_o, err_o, rdata_o, sel_o, mem_req_o, mem_we_o,
                              mem_addr_o[15:0], mem_wdata_o[3:0]}, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        addr0_i = 32'h100;
        rq.push_back('{30, 32'h0});
        req_i = 2'b01;
        repeat (3) @(negedge clk_i);
        chk("abort_req_before", mem_req_o, 1);
        #2 rst_i = 1'b1;
        #1 chk("abort_req_drop", mem_req_o, 0);
        chk("abort_addr_clear", mem_addr_o, 0);
        req_i = 2'b00;
        repeat (3) begin
            @(negedge clk_i);
            chk("abort_no_done", done_o, 0);
        end
        rq.delete();
        rst_i = 1'b0;
        @(negedge clk_i);
        mon_en = 1;
        lg = 1'b1;
        p = 2'b00;
        for (int k = 0; k < 48; k++) begin
            if (k < 9) s = steps[k];
            else begin
                s.add = 2'($urandom_range(0, 3));
                s.we = 1'($urandom_range(0, 1));
                s.addr = $urandom;
                s.wdata = $urandom;
                s.d = $urandom_range(0, 19);
                s.rd = $urandom;
                s.drop = ($urandom_range(0, 3) == 0);
            end
            if (p == 2'b00 && s.add == 2'b00) s.add = 2'b01;
            for (int i = 0; i < 2; i++)
                if (s.add[i] && !p[i]) begin
                    p[i] = 1'b1;
                    cw[i] = s.we;
                    ca[i] = s.addr;
                    cd[i] = s.wdata;
                end
            w = (p == 2'b11) ? ~lg : p[1];
            lg = w;
            eq.push_back('{w, cw[w], ca[w], cd[w],
                           (s.d < TIMEOUT && !cw[w]) ? s.rd : 32'h0,
                           s.d >= TIMEOUT, (s.d < TIMEOUT) ? s.d + 1 : TIMEOUT});
            rq.push_back('{s.d, s.rd});
            req_i = p;
            we_i = {cw[1], cw[0]};
            addr0_i = ca[0]; addr1_i = ca[1];
            wdata0_i = cd[0]; wdata1_i = cd[1];
            n = 0;
            got = 0;
            while (!got && n < 60) begin
                @(negedge clk_i);
                n++;
                if (s.drop && n == 3) req_i[w] = 1'b0;
                got = (done_o != 2'b00);
            end
            if (!got) begin
                chk("done_within_budget", n, 0);
                break;
            end
            p[w] = 1'b0;
        end
        req_i = 2'b00;
        repeat (3) @(negedge clk_i);
        chk("scoreboard_drained", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
